fetch_queue: RTL and testbench

- Small instruction prefetch queue between instruction_fetch (upstream, produces instruction + word PC) and control/decode (downstream, consumes one instruction per cycle).
- Decouples fetch from decode stalls; discards all queued instructions on a taken branch/jump redirect.
- Presents a NOP (32'h00000000, sll $0,$0,0) to decode whenever empty.

---
 rtl/fetch_queue_pkg.sv | 25 ++
 rtl/fetch_queue_storage.sv | 25 ++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and occupancy classification for the instruction prefetch path.
// Used by instruction_fetch, fetch_queue and control.
package fetch_queue_pkg;

    localparam int unsigned PC_W    = 30;
    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        OccEmpty,
        OccPartial,
        OccFull
    } occ_e;

    function automatic occ_e occ_state(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0) begin
            return OccEmpty;
        end
        if (cnt >= depth) begin
            return OccFull;
        end
        return OccPartial;
    endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Register array for fetch_queue entries: one synchronous write port and one
// combinational read port. Contents need no reset; the queue masks invalid heads.
module fq_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 62
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode. Presents a NOP when empty
// and discards every queued entry on a branch/jump redirect (flush).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = fetch_queue_pkg::PC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = PC_W + INSTR_W;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    occ_e               occ;
    logic [ENTRY_W-1:0] head;

    assign occ       = occ_state(32'(count_q), DEPTH);
    assign in_ready  = (occ != OccFull);
    assign out_valid = (occ != OccEmpty);
    assign count     = count_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    fq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign out_pc    = out_valid ? head[ENTRY_W-1:INSTR_W] : '0;
    assign out_instr = out_valid ? head[INSTR_W-1:0] : NOP_INSTR;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Redirect: drop everything, leave pointers aligned where they are.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for fill/drain plus hand-written
// sequences for streaming, flush and asynchronous reset.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [29:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [29:0] out_pc;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;

    int checks;
    int errors;

    fetch_queue #(
        .DEPTH (4),
        .PC_W  (30)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_instr;
        logic [29:0] in_pc;
        logic        out_ready;
        logic        flush;
        logic [2:0]  exp_count;
        logic        exp_out_valid;
        logic [29:0] exp_out_pc;
        logic [31:0] exp_out_instr;
        logic        exp_in_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic iv, input logic [31:0] ii, input logic [29:0] ip,
                           input logic ordy, input logic fl, input logic [2:0] ec,
                           input logic eov, input logic [29:0] epc, input logic [31:0] ein,
                           input logic eir);
        vec_t v;
        v.in_valid = iv; v.in_instr = ii; v.in_pc = ip; v.out_ready = ordy; v.flush = fl;
        v.exp_count = ec; v.exp_out_valid = eov; v.exp_out_pc = epc;
        v.exp_out_instr = ein; v.exp_in_ready = eir;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [2:0] ec, input logic eov,
                               input logic [29:0] epc, input logic [31:0] ein,
                               input logic eir);
        chk({tag, ".count"}, 64'(count), 64'(ec));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(eov));
        chk({tag, ".out_pc"}, 64'(out_pc), 64'(epc));
        chk({tag, ".out_instr"}, 64'(out_instr), 64'(ein));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(eir));
    endtask

    task automatic drive(input logic iv, input logic [31:0] ii, input logic [29:0] ip,
                         input logic ordy, input logic fl);
        in_valid = iv; in_instr = ii; in_pc = ip; out_ready = ordy; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Fill to full with decode stalled, try a fifth push, then drain in order.
        for (int k = 0; k < 4; k++) begin
            add_vec(1'b1, 32'h2008_0001 + 32'(k), 30'(k), 1'b0, 1'b0,
                    3'(k + 1), 1'b1, 30'h0, 32'h2008_0001, (k < 3));
        end
        add_vec(1'b1, 32'h2008_0005, 30'h4, 1'b0, 1'b0, 3'd4, 1'b1, 30'h0, 32'h2008_0001, 1'b0);
        add_vec(1'b0, 32'hdead_beef, 30'h3fff_ffff, 1'b1, 1'b0, 3'd3, 1'b1, 30'h1,
                32'h2008_0002, 1'b1);
        add_vec(1'b0, 32'hdead_beef, 30'h3fff_ffff, 1'b1, 1'b0, 3'd2, 1'b1, 30'h2,
                32'h2008_0003, 1'b1);
        add_vec(1'b0, 32'hdead_beef, 30'h3fff_ffff, 1'b1, 1'b0, 3'd1, 1'b1, 30'h3,
                32'h2008_0004, 1'b1);
        add_vec(1'b0, 32'hdead_beef, 30'h3fff_ffff, 1'b1, 1'b0, 3'd0, 1'b0, 30'h0,
                32'h0000_0000, 1'b1);

        drive(1'b0, 32'h0, 30'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #12;
        chk_outputs("reset", 3'd0, 1'b0, 30'h0, 32'h0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_outputs("idle", 3'd0, 1'b0, 30'h0, 32'h0, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].in_valid, vecs[i].in_instr, vecs[i].in_pc, vecs[i].out_ready,
                  vecs[i].flush);
            step();
            chk_outputs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_out_valid,
                        vecs[i].exp_out_pc, vecs[i].exp_out_instr, vecs[i].exp_in_ready);
        end

        // Streaming from empty: occupancy stays 1, each pc emerges one cycle after push.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h0000_0100 + 32'(k), 30'(k), 1'b1, 1'b0);
            step();
            chk_outputs($sformatf("stream%0d", k), 3'd1, 1'b1, 30'(k),
                        32'h0000_0100 + 32'(k), 1'b1);
        end
        drive(1'b0, 32'h0, 30'h0, 1'b1, 1'b0);
        step();
        chk_outputs("stream_drain", 3'd0, 1'b0, 30'h0, 32'h0, 1'b1);

        // Flush with a same-cycle push and pop at count 3.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h3000_0000 + 32'(k), 30'h20 + 30'(k), 1'b0, 1'b0);
            step();
        end
        chk_outputs("pre_flush", 3'd3, 1'b1, 30'h20, 32'h3000_0000, 1'b1);
        drive(1'b1, 32'h1111_1111, 30'h10, 1'b1, 1'b1);
        step();
        chk_outputs("flush", 3'd0, 1'b0, 30'h0, 32'h0, 1'b1);
        drive(1'b1, 32'h4444_4444, 30'h40, 1'b0, 1'b0);
        step();
        chk_outputs("post_flush", 3'd1, 1'b1, 30'h40, 32'h4444_4444, 1'b1);

        // Asynchronous reset between edges with count 3.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h5000_0000 + 32'(k), 30'h50 + 30'(k), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 30'h0, 1'b0, 1'b0);
        chk_outputs("pre_reset", 3'd3, 1'b1, 30'h40, 32'h4444_4444, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_outputs("async_reset", 3'd0, 1'b0, 30'h0, 32'h0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'h6666_6666, 30'h60, 1'b0, 1'b0);
        step();
        chk_outputs("after_reset", 3'd1, 1'b1, 30'h60, 32'h6666_6666, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
